// File: rtl/float_sq_mul_stream.sv
// float_sq_mul_stream
// Computes a*a*b (square mode) or a*b (multiply mode) on a parametrised
// IEEE-754-style format. One mantissa multiplier is shared between the square
// step and the multiply step, and an FSM sequences the two steps. Each step
// normalises and rounds to nearest-even. Subnormal inputs are flushed to zero.
// Both sides use a valid/ready handshake. The result is held until the
// consumer accepts it.
`timescale 1ns/1ps

module float_sq_mul_stream #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic [2:0]               out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  // Exponents are carried as signed EXP_W+2 bit values. That width is enough
  // to hold 2*emax - bias + 2 without wrapping.
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'(EMAX);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SQ, MUL, RND, HOLD} state_t;

  // Classification of the intermediate value between the two steps.
  typedef enum logic [1:0] {CL_NORM, CL_ZERO, CL_INF, CL_NAN} cls_t;

  state_t state, state_nxt;

  // Latched operands.
  logic [W-1:0] a_r, b_r;
  logic         mode_r;

  // Intermediate result (after SQ, then after MUL) and sticky flags.
  logic                     s_r;
  logic signed [EXP_W+1:0]  e_r;
  logic [MAN_W:0]           m_r;
  cls_t                     cls_r;
  logic                     inv_r, ovf_r, unf_r;

  // Operand fields.
  logic                     sa, sb;
  logic [EXP_W-1:0]         ea, eb;
  logic [MAN_W-1:0]         fa, fb;
  logic signed [EXP_W+1:0]  ea_s, eb_s;
  logic                     a_nan, a_inf, a_zero;
  logic                     b_nan, b_inf, b_zero;

  // Shared multiplier and rounding datapath.
  logic [MAN_W:0]           mul_x, mul_y;
  logic [2*MAN_W+1:0]       prod;
  logic                     prod_hi;
  logic [MAN_W:0]           mant_pre;
  logic                     guard, sticky, round_up;
  logic [MAN_W+1:0]         mant_sum;
  logic                     rnd_carry;
  logic [MAN_W:0]           mant_rnd;
  logic signed [EXP_W+1:0]  exp_base, exp_rnd;
  logic                     rnd_ovf, rnd_unf;

  // Result of the current step, registered in SQ and in MUL.
  logic                     stg_s;
  logic signed [EXP_W+1:0]  stg_e;
  logic [MAN_W:0]           stg_m;
  cls_t                     stg_cls;
  logic                     stg_inv, stg_ovf, stg_unf;

  logic [W-1:0]             pack_data;

  assign sa = a_r[W-1];
  assign ea = a_r[W-2:MAN_W];
  assign fa = a_r[MAN_W-1:0];
  assign sb = b_r[W-1];
  assign eb = b_r[W-2:MAN_W];
  assign fb = b_r[MAN_W-1:0];

  assign ea_s = {2'b00, ea};
  assign eb_s = {2'b00, eb};

  // Exponent 0 covers both zero and subnormal. Both are treated as signed zero.
  assign a_zero = (ea == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_zero = (eb == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  // State register.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge and simulation matches hardware.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and in_ready. Operands are accepted only in IDLE.
  // NOTE: every signal gets a default before the case. That way no path
  // leaves an output unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SQ;
      end
      SQ:      state_nxt = MUL;
      MUL:     state_nxt = RND;
      RND:     state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand select for the shared multiplier: a*a in SQ, intermediate*b otherwise.
  always_comb begin
    mul_x = m_r;
    mul_y = {1'b1, fb};
    if (state == SQ) begin
      mul_x = {1'b1, fa};
      mul_y = {1'b1, fa};
    end
  end

  assign prod = {{(MAN_W+1){1'b0}}, mul_x} * {{(MAN_W+1){1'b0}}, mul_y};

  // Normalise the [1,4) product, round to nearest-even and renormalise on carry.
  always_comb begin
    prod_hi = prod[2*MAN_W+1];
    if (prod_hi) begin
      mant_pre = prod[2*MAN_W+1:MAN_W+1];
      guard    = prod[MAN_W];
      sticky   = |prod[MAN_W-1:0];
    end else begin
      mant_pre = prod[2*MAN_W:MAN_W];
      guard    = prod[MAN_W-1];
      sticky   = |prod[MAN_W-2:0];
    end
    round_up  = guard & (sticky | mant_pre[0]);
    mant_sum  = {1'b0, mant_pre} + {{(MAN_W+1){1'b0}}, round_up};
    rnd_carry = mant_sum[MAN_W+1];
    mant_rnd  = rnd_carry ? mant_sum[MAN_W+1:1] : mant_sum[MAN_W:0];
    exp_base  = (state == SQ) ? (ea_s + ea_s - BIAS_S) : (e_r + eb_s - BIAS_S);
    exp_rnd   = exp_base + {{(EXP_W+1){1'b0}}, prod_hi}
                         + {{(EXP_W+1){1'b0}}, rnd_carry};
    rnd_ovf   = !exp_rnd[EXP_W+1] && (exp_rnd >= EMAX_S);
    rnd_unf   = exp_rnd[EXP_W+1] || (exp_rnd == '0);
  end

  // Step result: special cases first, then the rounded value with range checks.
  always_comb begin
    stg_s   = 1'b0;
    stg_e   = exp_rnd;
    stg_m   = mant_rnd;
    stg_cls = CL_NORM;
    stg_inv = 1'b0;
    stg_ovf = 1'b0;
    stg_unf = 1'b0;
    if (state == SQ) begin
      // In square mode, a*a is non-negative, so the final sign is sign(b).
      stg_s = mode_r ? sa : 1'b0;
      if (a_nan) begin
        stg_cls = CL_NAN;
        stg_inv = 1'b1;
      end else if (a_inf) begin
        stg_cls = CL_INF;
      end else if (a_zero) begin
        stg_cls = CL_ZERO;
      end else if (mode_r) begin
        stg_e = ea_s;
        stg_m = {1'b1, fa};
      end else if (rnd_ovf) begin
        stg_cls = CL_INF;
        stg_ovf = 1'b1;
      end else if (rnd_unf) begin
        stg_cls = CL_ZERO;
        stg_unf = 1'b1;
      end
    end else begin
      stg_s = s_r ^ sb;
      if (cls_r == CL_NAN || b_nan ||
          (cls_r == CL_INF && b_zero) || (cls_r == CL_ZERO && b_inf)) begin
        stg_cls = CL_NAN;
        stg_inv = 1'b1;
      end else if (cls_r == CL_INF || b_inf) begin
        stg_cls = CL_INF;
      end else if (cls_r == CL_ZERO || b_zero) begin
        stg_cls = CL_ZERO;
      end else if (rnd_ovf) begin
        stg_cls = CL_INF;
        stg_ovf = 1'b1;
      end else if (rnd_unf) begin
        stg_cls = CL_ZERO;
        stg_unf = 1'b1;
      end
    end
  end

  // Operand capture on accept, then step results. Flags clear on each accept.
  // NOTE: these datapath registers are not reset. Each one is written on
  // accept or in SQ/MUL before anything reads it.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_r    <= in_a;
          b_r    <= in_b;
          mode_r <= in_mode;
          inv_r  <= 1'b0;
          ovf_r  <= 1'b0;
          unf_r  <= 1'b0;
        end
      end
      SQ, MUL: begin
        s_r   <= stg_s;
        e_r   <= stg_e;
        m_r   <= stg_m;
        cls_r <= stg_cls;
        inv_r <= inv_r | stg_inv;
        ovf_r <= ovf_r | stg_ovf;
        unf_r <= unf_r | stg_unf;
      end
      default: ;
    endcase
  end

  // Pack the final intermediate into the output word format.
  always_comb begin
    case (cls_r)
      CL_NAN:  pack_data = QNAN;
      CL_INF:  pack_data = {s_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CL_ZERO: pack_data = {s_r, {(W-1){1'b0}}};
      default: pack_data = {s_r, e_r[EXP_W-1:0], m_r[MAN_W-1:0]};
    endcase
  end

  // Output register: loaded in RND, held in HOLD until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (state == RND) begin
      out_valid <= 1'b1;
      out_data  <= pack_data;
      out_flags <= {inv_r, ovf_r, unf_r};
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_float_sq_mul_stream.sv
// Testbench for float_sq_mul_stream.
// Drives directed single-precision vectors, backpressure and a mid-operation
// reset. It then checks half precision with one directed vector and random
// vectors against a model that rounds after every multiply.
`timescale 1ns/1ps

module tb_float_sq_mul_stream;

  logic clk = 1'b0;
  logic rst;

  // Single-precision instance.
  logic        in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_data;
  logic [2:0]  out_flags;

  // Half-precision instance.
  logic        h_in_valid, h_in_ready, h_in_mode, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_out_data;
  logic [2:0]  h_out_flags;

  int n_vec = 0;
  int n_err = 0;

  float_sq_mul_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  float_sq_mul_stream #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_mode(h_in_mode),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_data(h_out_data), .out_flags(h_out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Half-precision reference model.
  typedef enum int {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

  function automatic kind_t kind_of(input logic [15:0] x);
    if (x[14:10] == 5'd0)  return K_ZERO;
    if (x[14:10] == 5'd31) return (x[9:0] != 10'd0) ? K_NAN : K_INF;
    return K_NORM;
  endfunction

  function automatic void ref_mul(input int ma, input int mb, input int e_in,
                                  output int m, output int e);
    longint p, q, rem, half;
    int     sh;
    p    = longint'(ma) * longint'(mb);
    sh   = (p >= (longint'(1) << 21)) ? 11 : 10;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    e = e_in + sh - 10;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    m = int'(q);
  endfunction

  function automatic void range_chk(inout kind_t k, input int e, inout bit ovf, inout bit unf);
    if (k != K_NORM) return;
    if (e >= 31) begin
      k = K_INF;
      ovf = 1'b1;
    end else if (e <= 0) begin
      k = K_ZERO;
      unf = 1'b1;
    end
  endfunction

  function automatic void ref_hp(input logic [15:0] a, input logic [15:0] b, input logic mode,
                                 output logic [15:0] d, output logic [2:0] f);
    kind_t k1, kb;
    bit    s1, s2, inv, ovf, unf;
    int    e1, m1, ea, eb;
    ea  = int'(a[14:10]);
    eb  = int'(b[14:10]);
    k1  = kind_of(a);
    kb  = kind_of(b);
    inv = 1'b0; ovf = 1'b0; unf = 1'b0;
    e1  = ea;
    m1  = 1024 + int'(a[9:0]);
    if (mode) begin
      s1 = a[15];
    end else begin
      s1 = 1'b0;
      if (k1 == K_NAN) inv = 1'b1;
      else if (k1 == K_NORM) ref_mul(m1, m1, 2 * ea - 15, m1, e1);
      range_chk(k1, e1, ovf, unf);
    end
    s2 = s1 ^ b[15];
    if (k1 == K_NAN || kb == K_NAN || (k1 == K_INF && kb == K_ZERO) ||
        (k1 == K_ZERO && kb == K_INF)) begin
      k1  = K_NAN;
      inv = 1'b1;
    end else if (k1 == K_INF || kb == K_INF) begin
      k1 = K_INF;
    end else if (k1 == K_ZERO || kb == K_ZERO) begin
      k1 = K_ZERO;
    end else begin
      ref_mul(m1, 1024 + int'(b[9:0]), e1 + eb - 15, m1, e1);
      range_chk(k1, e1, ovf, unf);
    end
    case (k1)
      K_NAN:   d = 16'h7E00;
      K_INF:   d = {s2, 5'h1F, 10'h000};
      K_ZERO:  d = {s2, 15'h0000};
      default: d = {s2, e1[4:0], m1[9:0]};
    endcase
    f = {inv, ovf, unf};
  endfunction

  // Runs one operation with out_ready=1. It can optionally check latency and
  // the return to IDLE.
  task automatic run_vec(input bit hp, input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic mode,
                         input logic [31:0] ed, input logic [2:0] ef, input bit full);
    int lat, n;
    n = 0;
    while (!(hp ? h_in_ready : in_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (hp) begin
      h_in_valid = 1'b1; h_in_a = a[15:0]; h_in_b = b[15:0]; h_in_mode = mode;
      h_out_ready = 1'b1;
    end else begin
      in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    h_in_valid = 1'b0;
    lat = 0;
    while (!(hp ? h_out_valid : out_valid) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (full) check({tag, ":latency"}, lat, 3);
    check({tag, ":data"}, hp ? {16'h0000, h_out_data} : out_data, ed);
    check({tag, ":flags"}, {29'd0, hp ? h_out_flags : out_flags}, {29'd0, ef});
    @(posedge clk); #1;
    if (full) begin
      check({tag, ":valid_drop"}, {31'd0, hp ? h_out_valid : out_valid}, 32'd0);
      check({tag, ":ready_back"}, {31'd0, hp ? h_in_ready : in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] ra, rb, rd;
    logic [2:0]  rf;
    logic        rm;
    int          n;

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_mode = 1'b0; h_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset:in_ready",  {31'd0, in_ready},  32'd1);
    check("reset:out_valid", {31'd0, out_valid}, 32'd0);
    check("reset:out_data",  out_data,           32'd0);
    check("reset:out_flags", {29'd0, out_flags}, 32'd0);
    check("reset:h_valid",   {31'd0, h_out_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed single-precision vectors.
    run_vec(0, "sq_2x2x3",  32'h40000000, 32'h40400000, 1'b0, 32'h41400000, 3'b000, 1'b1);
    run_vec(0, "sq_neg1p5", 32'hBFC00000, 32'h40000000, 1'b0, 32'h40900000, 3'b000, 1'b0);
    run_vec(0, "mul_neg1p5",32'hBFC00000, 32'h40000000, 1'b1, 32'hC0400000, 3'b000, 1'b0);
    run_vec(0, "ovf",       32'h7F000000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b010, 1'b0);
    run_vec(0, "unf",       32'h1F800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b001, 1'b0);
    run_vec(0, "inf_x_0",   32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100, 1'b0);
    run_vec(0, "tie_even",  32'h3F800800, 32'h3F800000, 1'b0, 32'h3F801000, 3'b000, 1'b0);
    run_vec(0, "tie_up",    32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00002, 3'b000, 1'b0);
    run_vec(0, "rnd_carry", 32'h3FFFFFFF, 32'h3F800001, 1'b1, 32'h40000000, 3'b000, 1'b0);

    // Backpressure: the result stays stable and new operands are ignored.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h3FC00000; in_mode = 1'b1;
    @(posedge clk); #1;
    in_a = 32'h40000000; in_b = 32'h40000000; in_mode = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("bp:latency", n, 3);
    for (int i = 0; i < 3; i++) begin
      check("bp:data",     out_data,           32'h40100000);
      check("bp:in_ready", {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    check("bp:still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp:valid_drop", {31'd0, out_valid}, 32'd0);
    check("bp:ready_back", {31'd0, in_ready},  32'd1);
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("bp:no_extra", n, 0);

    // Reset while the operation is in MUL.
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40400000; in_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst:out_valid", {31'd0, out_valid}, 32'd0);
    check("rst:in_ready",  {31'd0, in_ready},  32'd1);
    check("rst:out_data",  out_data,           32'd0);
    rst = 1'b0;
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("rst:no_emit", n, 0);
    run_vec(0, "after_rst", 32'hBFC00000, 32'h40000000, 1'b0, 32'h40900000, 3'b000, 1'b1);

    // Half precision: one directed vector, then random vectors against the model.
    run_vec(1, "hp_2x2x3", 32'h4000, 32'h4200, 1'b0, 32'h4A00, 3'b000, 1'b1);
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      rm = 1'($urandom_range(0, 1));
      ref_hp(ra, rb, rm, rd, rf);
      run_vec(1, $sformatf("hp_rand%0d_%h_%h_%0d", i, ra, rb, rm),
              {16'h0000, ra}, {16'h0000, rb}, rm, {16'h0000, rd}, rf, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/float_sq_mul_stream.md
# float_sq_mul_stream

Parametrised successor to the float square-multiply unit in the inverse-square-root datapath. Computes a·a·b (square mode) or a·b (multiply mode) on a configurable IEEE-754-style format using one shared mantissa multiplier sequenced by an FSM. Uses a valid/ready handshake on both sides, so the Newton-iteration controller can stall the result. Results match a reference model that rounds after every multiply.

## Interface

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept operands; reset value 1
- in_a  in  W  operand a (squared in square mode)
- in_b  in  W  operand b
- in_mode  in  1  0 = a·a·b, 1 = a·b
- out_valid  out  1  result valid; reset value 0
- out_ready  in  1  consumer accepts result
- out_data  out  W  result; reset value 0
- out_flags  out  3  {invalid, overflow, underflow}; reset value 0

## Operation

- FSM states: IDLE, SQ, MUL, RND, HOLD. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_a, in_b, in_mode and go to SQ.
- SQ:
  - Square mode: multiply mant(a)·mant(a) with the hidden 1 restored, normalise, RNE-round to MAN_W. Exponent = 2·(ea−bias)+bias.
  - Multiply mode: pass a through unchanged.
  - Go to MUL.
- MUL: multiply the SQ result by b: normalise, RNE-round, exponent sum. Go to RND.
- RND:
  - Apply special-case and range checks.
  - Register out_data and out_flags, set out_valid=1, go to HOLD.
- HOLD:
  - out_data and out_flags stay stable while out_ready=0.
  - On out_valid&out_ready: out_valid←0, go to IDLE.
  - No new accept in this cycle.
- in_ready=1 only in IDLE.
- Arithmetic:
  - Exponent math uses signed EXP_W+2 bits.
  - Product is (MAN_W+1)·2 bits.
  - Round to nearest, ties to even.
  - Rounding carry renormalises and increments the exponent.
- Sign:
  - Square mode: sign(b).
  - Multiply mode: sign(a)^sign(b).
- Input handling:
  - Exponent 0 (zero or subnormal) is treated as signed zero (flush-to-zero).
- Special cases, in priority order:
  1. Any NaN input, or inf·0 in any stage → canonical qNaN (sign 0, exp all ones, fraction MSB=1); invalid=1.
  2. Any inf operand → inf with the computed sign.
  3. Any zero operand → zero with the computed sign.
- Range after any rounding step:
  - Biased exp ≥ 2^EXP_W−1 → inf with sign; overflow=1.
  - Biased exp ≤ 0 → signed zero; underflow=1.
  - Flags are sticky across SQ and MUL for that operation and cleared on each accept.
- Reset mid-operation: the next edge with rst=1 aborts. State→IDLE, out_valid=0, out_data=0, out_flags=0, in_ready=1. The partial result is discarded.

## Timing

- Accept at edge E0 → SQ registered at E1 → MUL at E2 → out_valid=1 after E3.
- Latency is 3 edges from accept to out_valid.
- Minimum initiation interval is 5 cycles: accept, SQ, MUL, RND, then a handshake with out_ready=1 back-to-IDLE.
- out_ready may be held low indefinitely; out_data stays stable throughout.
- in_valid while not in IDLE is ignored; inputs are not sampled.
- rst wins over any simultaneous handshake.

## Test plan

- Square mode, default params: a=0x40000000 (2.0), b=0x40400000 (3.0), out_ready=1 → out_data=0x41400000 (12.0), flags=0. out_valid asserts exactly 3 edges after accept.
- Sign and mode, default params:
  - a=0xBFC00000 (−1.5), b=0x40000000, mode 0 → 0x40900000 (4.5).
  - Same operands, mode 1 → 0xC0400000 (−3.0).
- Specials, default params:
  - a=0x7F000000, b=0x3F800000 → 0x7F800000, overflow=1.
  - a=0x1F800000 (2^−64), b=0x3F800000 → 0x00000000, underflow=1.
  - a=0x7F800000, b=0x00000000 → 0x7FC00000, invalid=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → out_data is constant, in_ready=0, and in_valid is ignored. Raise out_ready → one handshake, then in_ready=1.
- Reset mid-op: assert rst while in MUL → after the edge, out_valid=0, in_ready=1, no result is emitted. The next vector computes correctly.
- Half precision, EXP_W=5, MAN_W=10: a=0x4000 (2.0), b=0x4200 (3.0) → 0x4A00 (12.0). Then 100 random vectors are checked against a round-per-multiply reference model.
